// File: rtl/pkt_rr_arb.sv
// Two-port packet round-robin arbiter: per-port FWFT buffers, whole packets merged, registered output.
// Latency: eop written at edge N -> dout_sop at N+2; no input backpressure, overfull sources see drop pulses.
module pkt_rr_arb #(
  parameter int DEPTH   = 256,
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din0,
  input  logic        din0_vld,
  input  logic        din0_sop,
  input  logic        din0_eop,
  input  logic [15:0] din1,
  input  logic        din1_vld,
  input  logic        din1_sop,
  input  logic        din1_eop,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_port,
  output logic        drop0,
  output logic        drop1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;

  logic [1:0]       vld_v, sop_v, eop_v, rd_v, avail_v, drop_v;
  logic [1:0][15:0] din_a;
  logic [1:0][17:0] head_a;

  assign vld_v = {din1_vld, din0_vld};
  assign sop_v = {din1_sop, din0_sop};
  assign eop_v = {din1_eop, din0_eop};
  assign din_a = {din1, din0};
  assign drop0 = drop_v[0];
  assign drop1 = drop_v[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] used, pkt_cnt;
    logic          in_pkt;
    logic          room, accept, wr, wr_eop, rd_eop;

    // Admission looks only at the registered fill level; a sop always restarts the decision.
    assign room      = (DEPTH_C - used) >= MAX_C;
    assign accept    = vld_v[p] & sop_v[p] & room;
    assign drop_v[p] = vld_v[p] & sop_v[p] & ~room;
    assign wr        = accept | (vld_v[p] & ~sop_v[p] & in_pkt);
    assign wr_eop    = wr & eop_v[p];
    assign head_a[p] = mem[rd_ptr];
    assign rd_eop    = rd_v[p] & head_a[p][16];
    assign avail_v[p] = (pkt_cnt != '0);

    always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= {sop_v[p], eop_v[p], din_a[p]};
    end

    // A rejected packet leaves in_pkt clear, so its remaining words are ignored like strays.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        used    <= '0;
        pkt_cnt <= '0;
        in_pkt  <= 1'b0;
      end else begin
        if (wr)       wr_ptr <= wr_ptr + AW'(1);
        if (rd_v[p])  rd_ptr <= rd_ptr + AW'(1);
        case ({wr, rd_v[p]})
          2'b10:   used <= used + CW'(1);
          2'b01:   used <= used - CW'(1);
          default: ;
        endcase
        case ({wr_eop, rd_eop})
          2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
          2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
          default: ;
        endcase
        if (vld_v[p] && sop_v[p])      in_pkt <= room & ~eop_v[p];
        else if (vld_v[p] && eop_v[p]) in_pkt <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    rd_v      = 2'b00;
    case (state)
      IDLE: begin
        if (avail_v[0] && avail_v[1]) state_nxt = last ? SEND0 : SEND1;
        else if (avail_v[0])          state_nxt = SEND0;
        else if (avail_v[1])          state_nxt = SEND1;
      end
      SEND0: begin
        rd_v[0] = 1'b1;
        if (head_a[0][16]) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end
      SEND1: begin
        rd_v[1] = 1'b1;
        if (head_a[1][16]) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // dout and dout_port hold through idle cycles; only the qualifiers drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      dout_port <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      case (state)
        SEND0: begin
          {dout_sop, dout_eop, dout} <= head_a[0];
          dout_port <= 1'b0;
          dout_vld  <= 1'b1;
        end
        SEND1: begin
          {dout_sop, dout_eop, dout} <= head_a[1];
          dout_port <= 1'b1;
          dout_vld  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Directed bench for pkt_rr_arb: hand-computed output timelines per scenario.
module tb_pkt_rr_arb;

  logic        clk;
  logic        rst_n;
  logic [15:0] din0, din1;
  logic        din0_vld, din0_sop, din0_eop;
  logic        din1_vld, din1_sop, din1_eop;
  logic [15:0] dout;
  logic        dout_vld, dout_sop, dout_eop, dout_port;
  logic        drop0, drop1;

  int n_cmp = 0;
  int n_bad = 0;
  int pk, wd;

  typedef struct packed {
    logic        vld;
    logic        sop;
    logic        eop;
    logic        port;
    logic [15:0] d;
  } exp_t;

  pkt_rr_arb #(.DEPTH(256), .MAX_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .din0(din0), .din0_vld(din0_vld), .din0_sop(din0_sop), .din0_eop(din0_eop),
    .din1(din1), .din1_vld(din1_vld), .din1_sop(din1_sop), .din1_eop(din1_eop),
    .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_port(dout_port), .drop0(drop0), .drop1(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t w(input logic p, input logic [15:0] d, input logic s, input logic e);
    exp_t r;
    r.vld = 1'b1; r.sop = s; r.eop = e; r.port = p; r.d = d;
    return r;
  endfunction

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".vld"}, 32'(dout_vld), 32'(e.vld));
    if (e.vld) begin
      chk({tag, ".dout"}, 32'(dout), 32'(e.d));
      chk({tag, ".sop"}, 32'(dout_sop), 32'(e.sop));
      chk({tag, ".eop"}, 32'(dout_eop), 32'(e.eop));
      chk({tag, ".port"}, 32'(dout_port), 32'(e.port));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    din0 = '0; din0_vld = 1'b0; din0_sop = 1'b0; din0_eop = 1'b0;
    din1 = '0; din1_vld = 1'b0; din1_sop = 1'b0; din1_eop = 1'b0;
  endtask

  task automatic set0(input logic [15:0] d, input logic s, input logic e);
    din0 = d; din0_vld = 1'b1; din0_sop = s; din0_eop = e;
  endtask

  task automatic set1(input logic [15:0] d, input logic s, input logic e);
    din1 = d; din1_vld = 1'b1; din1_sop = s; din1_eop = e;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic exp_t exp1(input int k);
    exp_t r = '0;
    if (k >= 5 && k <= 8) r = w(1'b0, 16'hA000 + 16'(k - 5), k == 5, k == 8);
    return r;
  endfunction

  function automatic exp_t exp2(input int k);
    exp_t r = '0;
    if (k == 3 || k == 4)        r = w(1'b0, 16'h2000 + 16'(k - 3), k == 3, k == 4);
    else if (k == 6 || k == 7)   r = w(1'b1, 16'h2100 + 16'(k - 6), k == 6, k == 7);
    else if (k >= 9 && k <= 13)  r = w(1'b0, 16'h2010 + 16'(k - 9), k == 9, k == 13);
    else if (k >= 15 && k <= 19) r = w(1'b1, 16'h2110 + 16'(k - 15), k == 15, k == 19);
    else if (k == 21)            r = w(1'b0, 16'h2020, 1'b1, 1'b1);
    else if (k == 23)            r = w(1'b1, 16'h2120, 1'b1, 1'b1);
    return r;
  endfunction

  function automatic exp_t exp3(input int k);
    exp_t r = '0;
    if (k >= 9 && k <= 16)       r = w(1'b1, 16'h3100 + 16'(k - 9), k == 9, k == 16);
    else if (k >= 18 && k <= 20) r = w(1'b0, 16'h3000 + 16'(k - 18), k == 18, k == 20);
    else if (k >= 22 && k <= 29) r = w(1'b1, 16'h3110 + 16'(k - 22), k == 22, k == 29);
    else if (k >= 31 && k <= 38) r = w(1'b1, 16'h3120 + 16'(k - 31), k == 31, k == 38);
    return r;
  endfunction

  function automatic exp_t exp5(input int k);
    exp_t r = '0;
    if (k == 2)      r = w(1'b0, 16'h5000, 1'b1, 1'b1);
    else if (k == 4) r = w(1'b1, 16'h5100, 1'b1, 1'b1);
    return r;
  endfunction

  initial begin
    idle_in();
    rst_n = 1'b0;
    tick();
    chk("rst.dout", 32'(dout), 32'h0);
    chk("rst.vld", 32'(dout_vld), 32'h0);
    chk("rst.sop", 32'(dout_sop), 32'h0);
    chk("rst.eop", 32'(dout_eop), 32'h0);
    chk("rst.port", 32'(dout_port), 32'h0);
    chk("rst.drop0", 32'(drop0), 32'h0);
    chk("rst.drop1", 32'(drop1), 32'h0);
    tick();
    rst_n = 1'b1;

    // single 4-word packet on port 0
    for (int k = 0; k < 11; k++) begin
      idle_in();
      if (k < 4) set0(16'hA000 + 16'(k), k == 0, k == 3);
      tick();
      chk_out($sformatf("t1_e%0d", k), exp1(k));
    end

    // three packets (2, 5, 1 words) on both ports at once
    do_reset();
    for (int k = 0; k < 26; k++) begin
      idle_in();
      if (k < 8) begin
        if (k < 2)      begin pk = 0; wd = k; end
        else if (k < 7) begin pk = 1; wd = k - 2; end
        else            begin pk = 2; wd = 0; end
        set0(16'h2000 + 16'(pk * 16 + wd), k == 0 || k == 2 || k == 7, k == 1 || k == 6 || k == 7);
        set1(16'h2100 + 16'(pk * 16 + wd), k == 0 || k == 2 || k == 7, k == 1 || k == 6 || k == 7);
      end
      tick();
      chk_out($sformatf("t2_e%0d", k), exp2(k));
    end

    // port 1 streams 8-word packets, port 0 slips one 3-word packet in
    do_reset();
    for (int k = 0; k < 41; k++) begin
      idle_in();
      if (k < 24) set1(16'h3100 + 16'((k / 8) * 16 + (k % 8)), (k % 8) == 0, (k % 8) == 7);
      if (k >= 9 && k <= 11) set0(16'h3000 + 16'(k - 9), k == 9, k == 11);
      tick();
      chk_out($sformatf("t3_e%0d", k), exp3(k));
    end

    // admission threshold on port 1: accepted at used=192, rejected at used=200
    do_reset();
    for (int k = 0; k < 230; k++) begin
      idle_in();
      if (k < 210) set1(16'h4000 + 16'(k), k == 0 || k == 192 || k == 200, k == 209);
      #1;
      if (k == 0 || k == 192 || k == 200 || k == 201 || k == 209)
        chk($sformatf("t4_drop1_k%0d", k), 32'(drop1), 32'(k == 200));
      if (k == 200) chk("t4_drop0", 32'(drop0), 32'h0);
      tick();
      if (k >= 200) chk($sformatf("t4_vld_e%0d", k), 32'(dout_vld), 32'h0);
    end

    // simultaneous single-word packets
    do_reset();
    for (int k = 0; k < 6; k++) begin
      idle_in();
      if (k == 0) begin
        set0(16'h5000, 1'b1, 1'b1);
        set1(16'h5100, 1'b1, 1'b1);
      end
      tick();
      chk_out($sformatf("t5_e%0d", k), exp5(k));
    end

    // reset during the third word of a 6-word port 1 packet
    do_reset();
    for (int k = 0; k < 10; k++) begin
      idle_in();
      if (k < 6) set1(16'h6100 + 16'(k), k == 0, k == 5);
      tick();
      if (k >= 7) chk_out($sformatf("t6_e%0d", k), w(1'b1, 16'h6100 + 16'(k - 7), k == 7, 1'b0));
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst.dout", 32'(dout), 32'h0);
    chk("t6_rst.vld", 32'(dout_vld), 32'h0);
    chk("t6_rst.sop", 32'(dout_sop), 32'h0);
    chk("t6_rst.eop", 32'(dout_eop), 32'h0);
    chk("t6_rst.port", 32'(dout_port), 32'h0);
    chk("t6_rst.drop1", 32'(drop1), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("t6_quiet_%0d", k), 32'(dout_vld), 32'h0);
    end
    for (int k = 0; k < 4; k++) begin
      idle_in();
      if (k == 0) set0(16'h6A00, 1'b1, 1'b1);
      tick();
      chk_out($sformatf("t6_new_e%0d", k), (k == 2) ? w(1'b0, 16'h6A00, 1'b1, 1'b1) : exp_t'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
